tow_arena: RTL
==============

# tow_arena

Parametrised tug-of-war playfield engine: the next-generation core of the tug-of-war lab game. Two raw player buttons are synchronised and edge-detected internally, and each press moves a single lit position along an N-light field. Each round win increments a saturating per-player score, followed by a programmable pause and a re-centre. The match ends when a player reaches the target score. The board top level instantiates it with KEY[3] as the left player, KEY[0] as the right player, LEDR as the field and HEX displays driven from the scores.

## Interface
- N_LIGHTS, 9, field length; must be odd and ≥3. CENTER = N_LIGHTS/2 (integer division).
- SCORE_W, 3, width of each score counter.
- WIN_SCORE, 7, round wins needed to take the match; range 1..2^SCORE_W−1.
- PAUSE_CYCLES, 4, cycles the field stays dark after a round win; must be ≥1.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_left  in  1  raw, asynchronous left-player button, active-high (pressed = 1).
- btn_right  in  1  raw, asynchronous right-player button, active-high.
- lights  out  N_LIGHTS  playfield; index N_LIGHTS−1 is the left end, index 0 the right end.
- score_left  out  SCORE_W  left-player round wins.
- score_right  out  SCORE_W  right-player round wins.
- winner  out  2  last round winner: 00 none, 01 left, 10 right.
- round_over  out  1  one-cycle pulse on the cycle a round is won.
- match_over  out  1  high once either score reaches WIN_SCORE.

## Operation
- Input path, per button:
  - 2-flop synchroniser, followed by a delay flop.
  - press = sync2 & ~delay: one pulse per rising edge, regardless of how long the button is held.
  - All three flops reset to 1, so a button held through reset must be released and re-pressed before it counts.
- State machine: PLAY, PAUSE, DONE. Position register pos ranges 0..N_LIGHTS−1.
- PLAY:
  - lights = one-hot at pos.
  - Left press alone: pos+1. Right press alone: pos−1.
  - Both presses in the same cycle: no move. Neither press: hold.
  - Left press alone with pos = N_LIGHTS−1: left wins the round.
  - Right press alone with pos = 0: right wins the round.
  - A round win in either direction has these effects:
    - The winner's score increments.
    - winner is updated and round_over pulses.
    - If the new score equals WIN_SCORE, go to DONE.
    - Otherwise go to PAUSE and load the pause counter with PAUSE_CYCLES.
- PAUSE:
  - lights = all 0; presses are ignored and discarded.
  - The counter decrements each cycle. On the cycle it reaches 0, pos ← CENTER and the state becomes PLAY.
- DONE:
  - lights = all 0, match_over = 1. Scores and winner are frozen and all presses are ignored.
  - Only reset exits DONE.
- Scores never exceed WIN_SCORE, so they never wrap.

## Timing
- Reset values:
  - state PLAY, pos = CENTER, so lights = 1<<CENTER.
  - Both scores 0, winner 00, round_over 0, match_over 0, pause counter 0.
- Press latency: btn rises before edge k → sync1 captures at k, sync2 at k+1 → press pulse combinational during cycle k+1 → pos/lights change at edge k+2.
- A button must be low for at least 2 clk cycles between presses to register as separate presses.
- Round-win edge:
  - score, winner and the state change are all registered on the same edge.
  - lights go dark on that same edge.
  - round_over is high for exactly the following cycle.
- PAUSE duration: lights are dark for exactly PAUSE_CYCLES cycles. The centre light reappears PAUSE_CYCLES edges after the win edge.
- match_over rises on the same edge as the winning score's increment.
- Asynchronous reset mid-round, mid-pause or in DONE returns immediately to the reset values. Presses in flight in the synchroniser are discarded.

## Test plan
- Reset, idle 5 cycles → lights = 9'b000010000, scores 0/0, winner 00, round_over never high.
- Hold btn_left high for 20 cycles → exactly one move, to lights = 9'b000100000, appearing 2 edges after the rise; no further movement while held.
- 5 isolated left presses from centre (each 1 cycle high, 3 low) → lights walk 5→8, then the 5th press wins: lights = 0, score_left = 1, winner = 01, round_over high for 1 cycle. After 4 dark cycles, lights = 9'b000010000.
- btn_left and btn_right rising in the same cycle → no move. Then alternate left/right presses → light oscillates between indices 4 and 5.
- 7 right-win rounds (5 right presses each) → score_right 1..7. After the 7th: match_over = 1, winner = 10, lights = 0. Further presses on either button → no change.
- Assert reset during PAUSE in round 3 (score_left = 2) → immediately lights = 9'b000010000, scores 0, winner 00. A button held through reset produces no move until it is released and pressed again.

Source files
------------

// File: rtl/tow_arena.sv
// Tug-of-war playfield engine: two synchronised, edge-detected player buttons
// move a single light along an N-light field, with scoring, pause and match end.

module tow_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic sync1;
    logic sync2;
    logic delay;

    // All flops come out of reset high, so a button held through reset
    // looks like an old press and must be released before it counts again.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            delay <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            delay <= sync2;
        end
    end

    assign press = sync2 & ~delay;
endmodule

module tow_arena #(
    parameter int N_LIGHTS     = 9,
    parameter int SCORE_W      = 3,
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_left,
    input  logic                btn_right,
    output logic [N_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]  score_left,
    output logic [SCORE_W-1:0]  score_right,
    output logic [1:0]          winner,
    output logic                round_over,
    output logic                match_over
);
    localparam int POS_W = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;
    localparam int CNT_W = $clog2(PAUSE_CYCLES + 1);

    localparam logic [POS_W-1:0]    CENTER     = POS_W'(N_LIGHTS / 2);
    localparam logic [POS_W-1:0]    LEFT_END   = POS_W'(N_LIGHTS - 1);
    localparam logic [POS_W-1:0]    RIGHT_END  = '0;
    localparam logic [SCORE_W-1:0]  WIN_VALUE  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]    PAUSE_LOAD = CNT_W'(PAUSE_CYCLES);
    localparam logic [N_LIGHTS-1:0] ONE_LIGHT  = N_LIGHTS'(1);

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t             state, state_n;
    logic [POS_W-1:0]   pos, pos_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SCORE_W-1:0] score_left_n, score_right_n;
    logic [1:0]         winner_n;
    logic               round_over_n;
    logic               press_left;
    logic               press_right;

    tow_sync u_sync_left (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_left),
        .press (press_left)
    );

    tow_sync u_sync_right (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_right),
        .press (press_right)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_PLAY;
            pos         <= CENTER;
            cnt         <= '0;
            score_left  <= '0;
            score_right <= '0;
            winner      <= WIN_NONE;
            round_over  <= 1'b0;
        end else begin
            state       <= state_n;
            pos         <= pos_n;
            cnt         <= cnt_n;
            score_left  <= score_left_n;
            score_right <= score_right_n;
            winner      <= winner_n;
            round_over  <= round_over_n;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n       = state;
        pos_n         = pos;
        cnt_n         = cnt;
        score_left_n  = score_left;
        score_right_n = score_right;
        winner_n      = winner;
        round_over_n  = 1'b0;

        case (state)
            ST_PLAY: begin
                // Simultaneous presses cancel out; the pull is only one-sided.
                if (press_left && !press_right) begin
                    if (pos == LEFT_END) begin
                        score_left_n = score_left + SCORE_W'(1);
                        winner_n     = WIN_LEFT;
                        round_over_n = 1'b1;
                        if (score_left_n == WIN_VALUE) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_PAUSE;
                            cnt_n   = PAUSE_LOAD;
                        end
                    end else begin
                        pos_n = pos + POS_W'(1);
                    end
                end else if (press_right && !press_left) begin
                    if (pos == RIGHT_END) begin
                        score_right_n = score_right + SCORE_W'(1);
                        winner_n      = WIN_RIGHT;
                        round_over_n  = 1'b1;
                        if (score_right_n == WIN_VALUE) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_PAUSE;
                            cnt_n   = PAUSE_LOAD;
                        end
                    end else begin
                        pos_n = pos - POS_W'(1);
                    end
                end
            end

            ST_PAUSE: begin
                // The edge that takes the counter to zero also re-centres.
                if (cnt <= CNT_W'(1)) begin
                    cnt_n   = '0;
                    pos_n   = CENTER;
                    state_n = ST_PLAY;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_n = ST_DONE;
            end

            default: begin
                state_n = ST_PLAY;
                pos_n   = CENTER;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        lights = '0;
        if (state == ST_PLAY) begin
            lights = ONE_LIGHT << pos;
        end
    end

    assign match_over = (state == ST_DONE);
endmodule
